di_enc_decoder: RTL
===================

// Module: di_enc_decoder
// PURPOSE
//  Quadrature encoder receiver: consumes A/B/I lines (loopback of the DO encoder outputs or a field encoder).
//  Synchronises and de-glitches each line, decodes X4 quadrature into a signed position count, latches
//  position on index, measures clocks per A cycle, and flags illegal transitions.
//  Sits between the DI pin buffers and the DSP register read mux; lets the station self-check encoder frequency/direction.
// PARAMETERS
//  FILT_LEN  4   consecutive identical synchronised samples required before a filtered line changes (1..15)
//  CNT_W     32  width of position, index-latch and period counters
// PORTS
//  xclk          in   1      system clock, 75 MHz
//  reset         in   1      asynchronous, active-high; clears all state
//  enca_in       in   1      encoder A, asynchronous to xclk
//  encb_in       in   1      encoder B, asynchronous to xclk
//  enci_in       in   1      encoder index, asynchronous to xclk
//  clear_counts  in   1      sync, 1-cycle pulse from DSP; clears counts/flags (not filters)
//  pos_count     out  CNT_W  signed position, +1 per forward quadrature edge
//  index_latch   out  CNT_W  pos_count captured at last index rising edge
//  index_seen    out  1      sticky: at least one index edge since reset/clear
//  period_count  out  CNT_W  xclk cycles between last two filtered A rising edges
//  period_valid  out  1      period_count holds a complete measurement
//  dir_out       out  1      1 = last valid step forward (A leads B), 0 = reverse
//  quad_error    out  1      sticky: A and B changed in the same filtered sample
// BEHAVIOUR
//  - Reset (async, active-high): all outputs 0; sync and filter flops 0; period timer 0; decoder prev state 00.
//  - Sync: 2-flop synchroniser per line. Filter: per-line counter; filtered line takes the synced value after it
//    differs from the filtered value for FILT_LEN consecutive clocks; any agreeing sample zeroes the counter.
//    Pin edge -> filtered edge latency = 2 + FILT_LEN clocks (jitter +1).
//  - Decode state S={A,B} filtered vs registered prev P, evaluated every clock:
//    forward sequence 00->10->11->01->00: pos_count +1, dir_out<=1.
//    reverse sequence 00->01->11->10->00: pos_count -1, dir_out<=0.
//    S==P: no change. Both bits differ: pos_count unchanged, dir_out unchanged, quad_error<=1.
//    P<=S every clock. Outputs register one clock after filtered change.
//  - pos_count wraps modulo 2^CNT_W (0 - 1 = all ones; all ones + 1 = 0); no saturation.
//  - Index: on filtered I rising edge, index_latch <= value pos_count holds after the same clock's update
//    (i.e. includes a coincident step); index_seen<=1.
//  - Period: timer increments every clock, saturating at all ones. On filtered A rising edge: timer<=1;
//    if an earlier A rise has been seen since reset/clear, period_count<=timer and period_valid<=1,
//    else only arm. Saturated timer reports all ones. A stopped encoder leaves last period held.
//  - clear_counts: next clock pos_count, index_latch, index_seen, period_count, period_valid, quad_error,
//    timer, and arm flag <=0; dir_out kept; filters and P keep tracking. Clear wins over a coincident
//    step, index or A rise (event discarded, P still updated).
//  - reset asserted mid-operation: immediate clear; after release the first filtered change is decoded
//    against P=00 (non-zero line levels at release can produce one step or a quad_error; DSP clears after).
// TESTING
//  1 FILT_LEN=4; forward quadrature, one state every 10 clk, 4 full cycles from 00 -> pos_count=16,
//    dir_out=1, period_count=40, period_valid=1 after 2nd A rise, quad_error=0.
//  2 From reset, reverse 2 full cycles -> pos_count=0xFFFFFFF8, dir_out=0; then forward 8 steps -> 0.
//  3 Glitch: A high for 3 clk -> filtered A, pos_count unchanged; high for 4 clk -> pos_count=1
//    exactly 2+4+1 clocks after pin edge.
//  4 Drive AB 00->11 (both stable 10 clk) -> quad_error=1, pos_count unchanged; clear_counts -> quad_error=0.
//  5 Index rise coincident with forward step at pos 99 -> pos_count=100, index_latch=100, index_seen=1.
//  6 clear_counts on same clock as a decoded step -> pos_count=0; assert reset mid-run -> all outputs 0
//    same cycle; stop A for >2^32 clk (force timer) -> next period_count=0xFFFFFFFF.

Source files
------------

// File: rtl/di_enc_decoder.sv
// Quadrature encoder receiver: synchronises and filters A/B/I, decodes X4 quadrature into a position count,
// latches position on index, measures xclk cycles per A period and flags illegal A/B transitions.
module di_enc_decoder #(
    parameter int FILT_LEN = 4,
    parameter int CNT_W    = 32
) (
    input  logic             xclk,
    input  logic             reset,
    input  logic             enca_in,
    input  logic             encb_in,
    input  logic             enci_in,
    input  logic             clear_counts,
    output logic [CNT_W-1:0] pos_count,
    output logic [CNT_W-1:0] index_latch,
    output logic             index_seen,
    output logic [CNT_W-1:0] period_count,
    output logic             period_valid,
    output logic             dir_out,
    output logic             quad_error
);
    localparam logic [3:0]       FILT_MAX = 4'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ALL1     = {CNT_W{1'b1}};

    // Line order in the 3-bit vectors: bit 2 = A, bit 1 = B, bit 0 = I
    logic [2:0]       sync1_r;
    logic [2:0]       sync2_r;
    logic [2:0]       filt_r;
    logic [2:0][3:0]  fcnt_r;
    logic [1:0]       prev_r;
    logic             iprev_r;
    logic             armed_r;
    logic [CNT_W-1:0] timer_r;

    logic [1:0]       cur_s;
    logic             step_fwd_s;
    logic             step_rev_s;
    logic             step_bad_s;
    logic             a_rise_s;
    logic             i_rise_s;
    logic [CNT_W-1:0] pos_next_s;

    // Synchronise each line, then let it through only after FILT_LEN consecutive disagreeing samples
    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            filt_r  <= 3'b000;
            fcnt_r  <= {3{4'd0}};
        end else begin
            sync1_r <= {enca_in, encb_in, enci_in};
            sync2_r <= sync1_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    fcnt_r[i] <= 4'd0;
                end else if (fcnt_r[i] == FILT_MAX) begin
                    filt_r[i] <= sync2_r[i];
                    fcnt_r[i] <= 4'd0;
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + 4'd1;
                end
            end
        end
    end

    assign cur_s    = filt_r[2:1];
    assign a_rise_s = cur_s[1] & ~prev_r[1];
    assign i_rise_s = filt_r[0] & ~iprev_r;

    // Classify the {prev, current} A/B pair; forward order is 00 -> 10 -> 11 -> 01
    always_comb begin
        step_fwd_s = 1'b0;
        step_rev_s = 1'b0;
        step_bad_s = 1'b0;
        case ({prev_r, cur_s})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd_s = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_rev_s = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_bad_s = 1'b1;
            default:                                step_bad_s = 1'b0;
        endcase
    end

    // Position after this clock's step, so an index edge on the same clock captures it
    always_comb begin
        if (step_fwd_s) begin
            pos_next_s = pos_count + ONE;
        end else if (step_rev_s) begin
            pos_next_s = pos_count - ONE;
        end else begin
            pos_next_s = pos_count;
        end
    end

    // Counters, flags and period timer; a clear discards any coincident event but prev state keeps tracking
    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            prev_r       <= 2'b00;
            iprev_r      <= 1'b0;
            pos_count    <= ZERO;
            index_latch  <= ZERO;
            index_seen   <= 1'b0;
            period_count <= ZERO;
            period_valid <= 1'b0;
            dir_out      <= 1'b0;
            quad_error   <= 1'b0;
            timer_r      <= ZERO;
            armed_r      <= 1'b0;
        end else begin
            prev_r  <= cur_s;
            iprev_r <= filt_r[0];
            if (clear_counts) begin
                pos_count    <= ZERO;
                index_latch  <= ZERO;
                index_seen   <= 1'b0;
                period_count <= ZERO;
                period_valid <= 1'b0;
                quad_error   <= 1'b0;
                timer_r      <= ZERO;
                armed_r      <= 1'b0;
            end else begin
                pos_count <= pos_next_s;
                if (step_fwd_s) begin
                    dir_out <= 1'b1;
                end else if (step_rev_s) begin
                    dir_out <= 1'b0;
                end
                if (step_bad_s) begin
                    quad_error <= 1'b1;
                end
                if (i_rise_s) begin
                    index_latch <= pos_next_s;
                    index_seen  <= 1'b1;
                end
                if (a_rise_s) begin
                    timer_r <= ONE;
                    armed_r <= 1'b1;
                    if (armed_r) begin
                        period_count <= timer_r;
                        period_valid <= 1'b1;
                    end
                end else if (timer_r != ALL1) begin
                    timer_r <= timer_r + ONE;
                end
            end
        end
    end

endmodule
